// File: rtl/par2ser.sv
// Parallel-to-serial transmitter: DATA_W-bit words in over valid/ready, out MSB-first one bit
// per enabled clock, with a one-word holding buffer so consecutive words stream gaplessly.
module par2ser #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic              tx_en,
    output logic              tx_data,
    output logic              tx_val,
    output logic              tx_last,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic              hold_vld_r;
    logic [DATA_W-1:0] hold_data_r;
    logic              sh_vld_r;
    logic [DATA_W-1:0] sh_data_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              hold_vld_s;
    logic [DATA_W-1:0] hold_data_s;
    logic              sh_vld_s;
    logic [DATA_W-1:0] sh_data_s;
    logic [CNT_W-1:0]  cnt_s;

    logic              tx_val_s;
    logic              tx_last_s;
    logic              accept_s;
    logic              load_s;

    // Handshake and strobe decode; in_rdy depends on registered state only.
    always_comb begin
        tx_val_s  = sh_vld_r & tx_en;
        tx_last_s = tx_val_s & (cnt_r == CNT_LAST);
        accept_s  = in_val & ~hold_vld_r;
        // The shifter is free when idle or emitting its final bit, so a held word loads gaplessly.
        load_s    = hold_vld_r & (~sh_vld_r | tx_last_s);
    end

    // Next-state for the holding buffer and the shifter.
    always_comb begin
        hold_vld_s  = hold_vld_r;
        hold_data_s = hold_data_r;
        sh_vld_s    = sh_vld_r;
        sh_data_s   = sh_data_r;
        cnt_s       = cnt_r;

        // Accept needs an empty buffer and load needs a full one, so they never coincide.
        if (accept_s) begin
            hold_data_s = in_data;
            hold_vld_s  = 1'b1;
        end else if (load_s) begin
            hold_vld_s  = 1'b0;
        end else begin
            hold_vld_s  = hold_vld_r;
        end

        if (load_s) begin
            sh_data_s = hold_data_r;
            sh_vld_s  = 1'b1;
            cnt_s     = CNT_ZERO;
        end else if (tx_last_s) begin
            sh_vld_s  = 1'b0;
            cnt_s     = CNT_ZERO;
        end else if (tx_val_s) begin
            sh_data_s = {sh_data_r[DATA_W-2:0], 1'b0};
            cnt_s     = cnt_r + CNT_ONE;
        end else begin
            sh_data_s = sh_data_r;
            cnt_s     = cnt_r;
        end
    end

    // State registers; reset discards both the partial and the held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld_r  <= 1'b0;
            hold_data_r <= {DATA_W{1'b0}};
            sh_vld_r    <= 1'b0;
            sh_data_r   <= {DATA_W{1'b0}};
            cnt_r       <= CNT_ZERO;
        end else begin
            hold_vld_r  <= hold_vld_s;
            hold_data_r <= hold_data_s;
            sh_vld_r    <= sh_vld_s;
            sh_data_r   <= sh_data_s;
            cnt_r       <= cnt_s;
        end
    end

    assign in_rdy  = ~hold_vld_r;
    assign tx_data = sh_data_r[DATA_W-1];
    assign tx_val  = tx_val_s;
    assign tx_last = tx_last_s;
    assign busy    = hold_vld_r | sh_vld_r;

endmodule

// File: tb/tb_par2ser.sv
// Self-checking bench for par2ser: a word scoreboard fed at acceptance and drained by a
// 32-bit deserializer model watching tx_data/tx_val.
module tb_par2ser;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_val;
    logic        in_rdy;
    logic        tx_en;
    logic        tx_data;
    logic        tx_val;
    logic        tx_last;
    logic        busy;

    logic        en_force;
    logic        rand_mode;
    logic        rnd_en;

    int          total;
    int          bad;
    int          bitcnt;
    int          words_rx;
    logic [31:0] cur;
    logic [31:0] exp_q[$];

    par2ser #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .tx_val  (tx_val),
        .tx_last (tx_last),
        .busy    (busy)
    );

    assign tx_en = rand_mode ? rnd_en : en_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rnd_en = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_en = ($urandom_range(0, 9) != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Deserializer model + scoreboard; acceptances are pushed, completed words popped.
    initial begin
        bitcnt   = 0;
        words_rx = 0;
        cur      = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                bitcnt = 0;
            end else begin
                if (tx_val) begin
                    cur = {cur[30:0], tx_data};
                    bitcnt++;
                    if (bitcnt == 32) begin
                        chk("tx_last_at_bit32", 32'(tx_last), 32'd1);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_word", cur, 32'hxxxx_xxxx);
                        end else begin
                            chk("word", cur, exp_q.pop_front());
                        end
                        words_rx++;
                        bitcnt = 0;
                    end else if (tx_last) begin
                        chk("tx_last_early", 32'(tx_last), 32'd0);
                    end
                end else if (tx_last) begin
                    chk("tx_last_idle", 32'(tx_last), 32'd0);
                end
                if (in_val && in_rdy) exp_q.push_back(in_data);
            end
        end
    end

    // Called at posedge+1; presents word on the cycle in_rdy allows, scrambling data before that.
    task automatic send(input logic [31:0] word, input bit scramble);
        for (int k = 0; k < 300; k++) begin
            in_val = 1'b1;
            if (in_rdy) begin
                in_data = word;
                @(posedge clk);
                #1;
                in_val  = 1'b0;
                in_data = scramble ? $urandom : 32'd0;
                return;
            end
            in_data = scramble ? $urandom : word;
            @(posedge clk);
            #1;
        end
        in_val = 1'b0;
        chk("send_timeout", 32'(in_rdy), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (bitcnt == n) break;
        end
        chk("bits_reached", 32'(bitcnt), 32'(n));
    endtask

    initial begin
        int n;
        int ok;
        int base;
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        in_val    = 1'b0;
        in_data   = 32'd0;
        en_force  = 1'b1;
        rand_mode = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_rdy",  32'(in_rdy),  32'd1);
        chk("rst_tx_val",  32'(tx_val),  32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word: latency, 32 contiguous bits, tx_last only at the end, busy falls after.
        in_data = 32'hA5A5_0F0F;
        in_val  = 1'b1;
        @(negedge clk);
        chk("t1_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1 in_val = 1'b0;
        @(negedge clk);
        chk("t1_lat_no_val", 32'(tx_val), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_first_val", 32'(tx_val), 32'd1);
        chk("t1_first_bit", 32'(tx_data), 32'd1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (tx_last) break;
            @(negedge clk);
            if (tx_val) n++;
        end
        chk("t1_bit_count", 32'(n), 32'd32);
        @(negedge clk);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        wait_idle(50);

        // Back-to-back: three words, 96 contiguous valid bits, in_rdy low while hold full.
        fork
            begin
                send(32'hFFFF_0000, 1'b0);
                send(32'h1234_5678, 1'b0);
                send(32'h8000_0001, 1'b0);
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (tx_val) break;
                end
                n = tx_val ? 1 : 0;
                for (int j = 1; j < 96; j++) begin
                    @(negedge clk);
                    if (tx_val) n++;
                    if (j == 10) chk("t2_rdy_low", 32'(in_rdy), 32'd0);
                end
                chk("t2_contiguous", 32'(n), 32'd96);
                @(negedge clk);
                chk("t2_end_idle", 32'(tx_val), 32'd0);
            end
        join
        @(posedge clk);
        #1;
        wait_idle(100);

        // Stall after 10 bits: outputs hold bit 21 with tx_val low, then resume.
        send(32'hDEAD_BEEF, 1'b0);
        wait_bits(10);
        @(posedge clk);
        #1 en_force = 1'b0;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!tx_val && tx_data) ok++;
        end
        chk("t3_stall_hold", 32'(ok), 32'd5);
        @(posedge clk);
        #1 en_force = 1'b1;
        wait_idle(100);

        // Reset mid-word with a second word held; nothing of either may appear afterwards.
        send(32'hCAFE_F00D, 1'b0);
        send(32'h5555_AAAA, 1'b0);
        wait_bits(12);
        chk("t4_hold_full", 32'(in_rdy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t4_rst_tx_val", 32'(tx_val), 32'd0);
        chk("t4_rst_busy",   32'(busy),   32'd0);
        chk("t4_rst_in_rdy", 32'(in_rdy), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        ok = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_val || busy) ok++;
        end
        chk("t4_no_residue", 32'(ok), 32'd0);
        @(posedge clk);
        #1;
        send(32'h0000_0001, 1'b0);
        wait_idle(100);

        // Backpressure: data scrambles every cycle until the accepting edge.
        send(32'h0BAD_F00D, 1'b1);
        send(32'h1357_9BDF, 1'b1);
        send(32'h2468_ACE0, 1'b1);
        wait_idle(200);

        // Loopback: random words, random idle gaps, random downstream stalls.
        base      = words_rx;
        rand_mode = 1'b1;
        for (int w = 0; w < 1000; w++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 1'b0);
        end
        wait_idle(2000);
        rand_mode = 1'b0;
        chk("t6_word_count", 32'(words_rx - base), 32'd1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
